reg_scoreboard: RTL
===================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have parameter REG_NUM, default 32, meaning the number of architectural registers tracked.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register address width (REG_NUM = 2^ADDR_W).
REQ-003 The block SHALL have parameter READ_PORTS, default 2, meaning the number of source-operand read ports checked per cycle.
REQ-004 The block SHALL have parameter LAT_W, default 2, meaning the latency field width (maximum latency 2^LAT_W-1).
REQ-005 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1, reset; asynchronous, active-low.
REQ-007 Port read_en, input, READ_PORTS, per-port read enable from ID decode.
REQ-008 Port read_addr, input, READ_PORTS*ADDR_W, flattened read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 Port issue_valid, input, 1, the ID-stage instruction requests issue this cycle.
REQ-010 Port issue_write_en, input, 1, the issuing instruction writes a register.
REQ-011 Port issue_write_addr, input, ADDR_W, destination register of the issuing instruction.
REQ-012 Port issue_latency, input, LAT_W, number of cycles until the result is forwardable; 0 means forwardable next cycle.
REQ-013 Port flush, input, 1, pipeline flush (branch mispredict or exception).
REQ-014 Port stall, output, 1, ID SHALL hold; combinational.
REQ-015 Port port_hazard, output, READ_PORTS, per-port hazard flag; combinational.
REQ-016 Port issue_accept, output, 1, issue_valid & ~stall; combinational.
REQ-017 Port busy_vec, output, REG_NUM, bit r is 1 when cnt[r] != 0; registered.

Function
REQ-018 The block SHALL hold one LAT_W-bit down-counter cnt[r] for each register r in 1..REG_NUM-1; register 0 SHALL never be tracked, and busy_vec[0] SHALL be 0.
REQ-019 port_hazard[i] SHALL equal read_en[i] & (addr_i != 0) & (cnt[addr_i] != 0), using pre-update state.
REQ-020 stall SHALL be the OR of port_hazard while flush is 0, and SHALL be 0 while flush is 1.
REQ-021 Each cycle, every nonzero cnt[r] SHALL decrement by 1, and a zero counter SHALL remain 0 (no wrap).
REQ-022 On issue_accept & issue_write_en & (issue_write_addr != 0), cnt[waddr] SHALL load max(cnt[waddr]-1 saturated at 0, issue_latency), so that WAW never shortens a pending interval.
REQ-023 The issue load (REQ-022) SHALL take precedence over the decrement (REQ-021) for the same register in the same cycle.
REQ-024 A write to register 0, or any issue while issue_accept is 0, SHALL leave all counters unchanged apart from the decrement.
REQ-025 flush=1 SHALL clear every counter to 0 at the next edge and SHALL override any simultaneous issue.
REQ-026 Latency SHALL be as follows: an instruction accepted at edge N with latency L SHALL cause hazards on its destination for cycles N+1..N+L, with hazard-free reads at cycle N+L+1.
REQ-027 The block SHALL have no internal FSM beyond the counters; stall SHALL not depend on issue_valid.

Reset
REQ-028 While rst=0, all cnt[r] SHALL be 0, busy_vec SHALL be 0, stall and port_hazard SHALL be 0, and any statistic counter SHALL be 0, asynchronously.
REQ-029 Reset asserted mid-interval SHALL abandon all pending entries, and the first cycle after release SHALL see no hazards.

Configuration
REQ-030 With macro SCOREBOARD_STATS_EN defined, the block SHALL add output stall_cycles (16 bits, registered), incremented each cycle where stall=1 and saturating at 16'hFFFF.
REQ-031 Without SCOREBOARD_STATS_EN, stall_cycles SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 The bench SHALL issue a write to r5 with latency 2, then read r5 on port 0 for the next 3 cycles -> stall=1,1,0; busy_vec[5] = 1,1,0.
REQ-033 The bench SHALL issue a write to r0 with latency 3, then read r0 -> stall=0 and busy_vec=0 throughout.
REQ-034 The bench SHALL issue r7 with latency 3, then one cycle later issue r7 with latency 1 (reads disabled) -> cnt[r7] reloads to 2 and the hazard ends 3 cycles after the first issue.
REQ-035 The bench SHALL put r3 busy with latency 3 and assert flush together with issue of r4 with latency 2 -> next cycle busy_vec=0 and reads of r3/r4 give stall=0.
REQ-036 The bench SHALL put r9 busy on port 1 only, read r9 on port 1 and r2 on port 0 -> port_hazard=2'b10, stall=1, issue_accept=0, and no counter loaded.
REQ-037 The bench SHALL drive rst low mid-interval with r6 busy -> busy_vec=0 immediately; with SCOREBOARD_STATS_EN, stall_cycles SHALL count 2 after a 2-cycle stall and SHALL saturate when forced near 16'hFFFF.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: ID-stage <-> scoreboard signals; stall_cycles exists only with SCOREBOARD_STATS_EN
interface reg_scoreboard_if #(
   parameter int REG_NUM    = 32,
   parameter int ADDR_W     = 5,
   parameter int READ_PORTS = 2,
   parameter int LAT_W      = 2
);
   logic [READ_PORTS-1:0]        read_en;
   logic [READ_PORTS*ADDR_W-1:0] read_addr;
   logic                         issue_valid;
   logic                         issue_write_en;
   logic [ADDR_W-1:0]            issue_write_addr;
   logic [LAT_W-1:0]             issue_latency;
   logic                         flush;
   logic                         stall;
   logic [READ_PORTS-1:0]        port_hazard;
   logic                         issue_accept;
   logic [REG_NUM-1:0]           busy_vec;
`ifdef SCOREBOARD_STATS_EN
   logic [15:0]                  stall_cycles;
   modport master (
      output read_en, read_addr, issue_valid, issue_write_en, issue_write_addr, issue_latency, flush,
      input  stall, port_hazard, issue_accept, busy_vec, stall_cycles
   );
   modport slave (
      input  read_en, read_addr, issue_valid, issue_write_en, issue_write_addr, issue_latency, flush,
      output stall, port_hazard, issue_accept, busy_vec, stall_cycles
   );
`else
   modport master (
      output read_en, read_addr, issue_valid, issue_write_en, issue_write_addr, issue_latency, flush,
      input  stall, port_hazard, issue_accept, busy_vec
   );
   modport slave (
      input  read_en, read_addr, issue_valid, issue_write_en, issue_write_addr, issue_latency, flush,
      output stall, port_hazard, issue_accept, busy_vec
   );
`endif
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register latency down-counters flagging RAW hazards to ID; SCOREBOARD_STATS_EN adds stall_cycles
module reg_scoreboard #(
   parameter int REG_NUM    = 32,
   parameter int ADDR_W     = 5,
   parameter int READ_PORTS = 2,
   parameter int LAT_W      = 2
) (
   input logic             clk,
   input logic             rst,
   reg_scoreboard_if.slave sb
);
   logic [LAT_W-1:0]      w_cnt [REG_NUM];
   logic [READ_PORTS-1:0] w_hazard;
   logic                  w_stall;
   logic                  w_load;

   for (genvar i = 0; i < READ_PORTS; i++) begin : g_port
      logic [ADDR_W-1:0] w_addr;
      assign w_addr      = sb.read_addr[i*ADDR_W +: ADDR_W];
      assign w_hazard[i] = sb.read_en[i] && w_addr != '0 && w_cnt[w_addr] != '0;
   end

   assign w_stall         = |w_hazard && !sb.flush;
   assign w_load          = sb.issue_accept && sb.issue_write_en && sb.issue_write_addr != '0;
   assign sb.stall        = w_stall;
   assign sb.port_hazard  = w_hazard;
   assign sb.issue_accept = sb.issue_valid && !w_stall;

   for (genvar r = 0; r < REG_NUM; r++) begin : g_reg
      if (r == 0) begin : g_zero
         assign w_cnt[r] = '0;
      end else begin : g_trk
         logic [LAT_W-1:0] r_cnt;
         logic [LAT_W-1:0] w_dec;
         assign w_dec = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
         // flush clears, a new writer keeps the longer of old and new intervals, otherwise count down
         always_ff @(posedge clk or negedge rst)
            if (!rst) r_cnt <= '0;
            else if (sb.flush) r_cnt <= '0;
            else if (w_load && sb.issue_write_addr == ADDR_W'(r)) r_cnt <= (w_dec > sb.issue_latency) ? w_dec : sb.issue_latency;
            else r_cnt <= w_dec;
         assign w_cnt[r] = r_cnt;
      end
      assign sb.busy_vec[r] = w_cnt[r] != '0;
   end

`ifdef SCOREBOARD_STATS_EN
   logic [15:0] r_stall_cycles;
   // count stalled cycles, holding at the maximum value
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_stall_cycles <= '0;
      else if (w_stall && r_stall_cycles != 16'hFFFF) r_stall_cycles <= r_stall_cycles + 16'd1;
   assign sb.stall_cycles = r_stall_cycles;
`endif
endmodule
